// File: rtl/sd_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_piso_serializer
//  Description : Parallel-in / serial-out stage feeding the sd_1011 sequence
//                detector. Words are taken over a valid/ready handshake and
//                emitted one bit per clock. A one-word holding register lets
//                consecutive words stream with no idle bits between them.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic             signal_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_accept;
    logic               w_load_point;

    // Outputs decode registers only, so no input reaches an output combinationally.
    assign din_ready  = !hold_full_q;
    assign bit_valid  = (state_q == ST_SHIFT);
    assign signal_out = (state_q == ST_SHIFT) ? (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0])
                                              : IDLE_LEVEL;
    assign word_done  = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign busy       = (state_q == ST_SHIFT) || hold_full_q;

    assign w_accept     = din_valid && !hold_full_q;
    // The shifter can take a new word when idle or while its last bit is on the line.
    assign w_load_point = (state_q == ST_IDLE) || (cnt_q == CNT_LAST);

    // Next-state logic: abort flush, load from hold or bypass, otherwise shift.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;

        if (abort) begin
            // Abort wins over any accept offered on the same edge.
            state_d     = ST_IDLE;
            hold_full_d = 1'b0;
            cnt_d       = '0;
        end else if (w_load_point) begin
            cnt_d = '0;
            if (hold_full_q) begin
                // din_ready is low here, so no accept can coincide.
                sr_d        = hold_q;
                hold_full_d = 1'b0;
                state_d     = ST_SHIFT;
            end else if (w_accept) begin
                // Bypass: the word goes straight into the shifter.
                sr_d    = din;
                state_d = ST_SHIFT;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            // Mid-word: advance the shifter, zero-filling behind the output end.
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end else begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_ONE;
            if (w_accept) begin
                hold_d      = din;
                hold_full_d = 1'b1;
            end
        end
    end

    // State registers; reset drops any word in flight or pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_piso_serializer
//  Description : Table-driven directed bench for sd_piso_serializer, with an
//                MSB-first and an LSB-first instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_piso_serializer;

    logic       clk;
    logic       rst;

    logic [7:0] m_din;
    logic       m_valid, m_abort;
    logic       m_ready, m_so, m_bv, m_wd, m_busy;

    logic [7:0] l_din;
    logic       l_valid, l_abort;
    logic       l_ready, l_so, l_bv, l_wd, l_busy;

    int errors = 0;
    int checks = 0;

    sd_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(m_din), .din_valid(m_valid), .din_ready(m_ready),
        .abort(m_abort), .signal_out(m_so), .bit_valid(m_bv), .word_done(m_wd), .busy(m_busy)
    );

    sd_piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(l_din), .din_valid(l_valid), .din_ready(l_ready),
        .abort(l_abort), .signal_out(l_so), .bit_valid(l_bv), .word_done(l_wd), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ab;
        logic       e_bv;
        logic       e_so;
        logic       e_wd;
        logic       e_rdy;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [7:0] d, logic ab,
                                logic bv, logic so, logic wd, logic rdy, logic bsy);
        vec_t r;
        r.v = v; r.d = d; r.ab = ab;
        r.e_bv = bv; r.e_so = so; r.e_wd = wd; r.e_rdy = rdy; r.e_busy = bsy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_m_idle(input string tag);
        chk({tag, " bit_valid"},  {31'd0, m_bv},    32'd0);
        chk({tag, " signal_out"}, {31'd0, m_so},    32'd0);
        chk({tag, " word_done"},  {31'd0, m_wd},    32'd0);
        chk({tag, " din_ready"},  {31'd0, m_ready}, 32'd1);
        chk({tag, " busy"},       {31'd0, m_busy},  32'd0);
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] lw;
        logic [3:0] det_sh;
        int         det_row;
        int         det_cnt;

        rst = 1'b0;
        m_valid = 1'b1; m_din = 8'hFF; m_abort = 1'b0;
        l_valid = 1'b1; l_din = 8'hFF; l_abort = 1'b0;

        // ---- Reset held with din_valid high: idle outputs, no accept
        repeat (3) step();
        chk_m_idle("reset");
        chk("reset lsb bit_valid", {31'd0, l_bv}, 32'd0);
        m_valid = 1'b0; l_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk_m_idle("post-reset");

        // ---- Build vector table
        // Single word 8'hB0 from idle.
        vecs.push_back(mk(1, 8'hB0, 0, 0, 0, 0, 1, 0));
        w = 8'hB0;
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 8'h00, 0, 1, w[7-i], (i == 7), 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0));
        // Back-to-back 8'hA5 then 8'h3C.
        vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 1, 0));
        w = 8'hA5;
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk((i == 0), 8'h3C, 0, 1, w[7-i], (i == 7), (i == 0), 1));
        w = 8'h3C;
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 8'h00, 0, 1, w[7-i], (i == 7), 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0));
        // Abort during bit 3 of 8'h81 with 8'hFF pending in hold.
        vecs.push_back(mk(1, 8'h81, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 8'hFF, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0));
        // Abort together with an offered word while idle: word discarded.
        vecs.push_back(mk(1, 8'hFF, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0));

        // ---- Apply table; also track a 1011 detector over rows 0..9
        det_sh  = 4'b0000;
        det_row = -1;
        det_cnt = 0;
        for (int r = 0; r < vecs.size(); r++) begin
            m_valid = vecs[r].v;
            m_din   = vecs[r].d;
            m_abort = vecs[r].ab;
            chk($sformatf("vec%0d bit_valid", r),  {31'd0, m_bv},    {31'd0, vecs[r].e_bv});
            chk($sformatf("vec%0d signal_out", r), {31'd0, m_so},    {31'd0, vecs[r].e_so});
            chk($sformatf("vec%0d word_done", r),  {31'd0, m_wd},    {31'd0, vecs[r].e_wd});
            chk($sformatf("vec%0d din_ready", r),  {31'd0, m_ready}, {31'd0, vecs[r].e_rdy});
            chk($sformatf("vec%0d busy", r),       {31'd0, m_busy},  {31'd0, vecs[r].e_busy});
            if (r < 10 && m_bv) begin
                det_sh = {det_sh[2:0], m_so};
                if (det_sh == 4'b1011) begin
                    det_cnt++;
                    det_row = r;
                end
            end
            step();
        end
        m_valid = 1'b0; m_abort = 1'b0;
        // The 4th bit of 8'hB0 is on the line in row 4; the detector fires once.
        chk("detector hits", det_cnt, 32'd1);
        chk("detector row",  det_row, 32'd4);

        // ---- LSB-first: 8'h0D -> 1,0,1,1,0,0,0,0
        l_valid = 1'b1; l_din = 8'h0D;
        chk("lsb idle bit_valid", {31'd0, l_bv}, 32'd0);
        step();
        l_valid = 1'b0; l_din = 8'h00;
        lw = 8'b0000_1101;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb bit%0d signal_out", i), {31'd0, l_so}, {31'd0, lw[i]});
            chk($sformatf("lsb bit%0d bit_valid", i),  {31'd0, l_bv}, 32'd1);
            chk($sformatf("lsb bit%0d word_done", i),  {31'd0, l_wd}, {31'd0, (i == 7)});
            step();
        end
        chk("lsb end bit_valid", {31'd0, l_bv},   32'd0);
        chk("lsb end busy",      {31'd0, l_busy}, 32'd0);

        // ---- Async reset mid-word with a word pending in hold
        m_valid = 1'b1; m_din = 8'hAA;
        step();
        m_din = 8'h55;
        step();
        m_valid = 1'b0;
        repeat (3) step();
        // Bit 5 of 8'hAA (MSB first) is on the line now.
        chk("pre-reset bit_valid", {31'd0, m_bv},    32'd1);
        chk("pre-reset signal_out", {31'd0, m_so},   32'd1);
        chk("pre-reset din_ready", {31'd0, m_ready}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk_m_idle("async reset");
        @(negedge clk);
        #1;
        rst = 1'b1;
        step();
        chk_m_idle("after release");

        m_valid = 1'b1; m_din = 8'hFF;
        step();
        m_valid = 1'b0; m_din = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ff bit%0d signal_out", i), {31'd0, m_so}, 32'd1);
            chk($sformatf("ff bit%0d bit_valid", i),  {31'd0, m_bv}, 32'd1);
            chk($sformatf("ff bit%0d word_done", i),  {31'd0, m_wd}, {31'd0, (i == 7)});
            step();
        end
        chk_m_idle("ff end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
